// File: rtl/branch_sequencer.sv
// Fetch/decode/execute/commit sequencer with flag-, register- and link-branches.
// Optional macro LINK_REG_EN: bl writes prog_count+1 through link_we/link_data.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        branch,
  input  logic [1:0]  branch_group,
  input  logic [5:0]  function_code,
  input  logic [31:0] reg_value,
  input  logic [31:0] branch_address,
  input  logic        alu_done,
  input  logic        flags_we,
  input  logic        negative,
  input  logic        zero,
  input  logic        carry,
  output logic [31:0] prog_count,
  output logic        flush,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        illegal,
  output logic [2:0]  flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;
  logic        br_q, br_d;
  logic [1:0]  grp_q, grp_d;
  logic [5:0]  fn_q, fn_d;
  logic [31:0] rv_q, rv_d;
  logic [31:0] ba_q, ba_d;

  logic        taken;
  logic        bad;
  logic [31:0] target;
`ifdef LINK_REG_EN
  logic        is_link;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
      br_q    <= 1'b0;
      grp_q   <= 2'b00;
      fn_q    <= 6'd0;
      rv_q    <= 32'd0;
      ba_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      br_q    <= br_d;
      grp_q   <= grp_d;
      fn_q    <= fn_d;
      rv_q    <= rv_d;
      ba_q    <= ba_d;
    end
  end

  // Branch resolution from captured fields; flag tests see only flags_q.
  always_comb begin
    taken  = 1'b0;
    bad    = 1'b0;
    target = ba_q;
`ifdef LINK_REG_EN
    is_link = 1'b0;
`endif
    case (grp_q)
      2'b00: begin
        case (fn_q)
          6'd0: begin
            taken  = 1'b1;
            target = rv_q;
          end
          6'd1:    taken = rv_q[31];
          6'd2:    taken = (rv_q == 32'd0);
          6'd3:    taken = (rv_q != 32'd0);
          default: bad = 1'b1;
        endcase
      end
      2'b01: begin
        case (fn_q)
          6'd0:    taken = 1'b1;
          6'd1:    taken = flags_q[0];
          6'd2:    taken = ~flags_q[0];
          default: bad = 1'b1;
        endcase
      end
      2'b10: begin
        if (fn_q == 6'd0) begin
          taken = 1'b1;
`ifdef LINK_REG_EN
          is_link = 1'b1;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flags_d     = flags_q;
    br_d        = br_q;
    grp_d       = grp_q;
    fn_d        = fn_q;
    rv_d        = rv_q;
    ba_d        = ba_q;
    fetch_req   = 1'b0;
    instr_ready = 1'b0;
    flush       = 1'b0;
    illegal     = 1'b0;
    link_we     = 1'b0;
    link_data   = 32'd0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          br_d    = branch;
          grp_d   = branch_group;
          fn_d    = function_code;
          rv_d    = reg_value;
          ba_d    = branch_address;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (br_q) begin
          state_d = S_COMMIT;
        end else if (alu_done) begin
          state_d = S_COMMIT;
          if (flags_we) flags_d = {negative, zero, carry};
        end
      end
      S_COMMIT: begin
        state_d = S_FETCH;
        illegal = br_q & bad;
        if (br_q && taken) begin
          pc_d  = target;
          flush = 1'b1;
        end else begin
          pc_d = pc_q + 32'd1;
        end
`ifdef LINK_REG_EN
        if (br_q && is_link) begin
          link_we   = 1'b1;
          link_data = pc_q + 32'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign prog_count = pc_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed plus randomized bench for branch_sequencer against a
// per-instruction reference model of prog_count, flags and pulses.
module tb_branch_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic        fetch_ack;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic [1:0]  branch_group;
  logic [5:0]  function_code;
  logic [31:0] reg_value;
  logic [31:0] branch_address;
  logic        alu_done;
  logic        flags_we;
  logic        negative;
  logic        zero;
  logic        carry;
  logic [31:0] prog_count;
  logic        flush;
  logic        link_we;
  logic [31:0] link_data;
  logic        illegal;
  logic [2:0]  flags;

  int vectors = 0;
  int errs = 0;

  logic [31:0] m_pc;
  logic [2:0]  m_flags;

  branch_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .fetch_req(fetch_req),
    .fetch_ack(fetch_ack),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch(branch),
    .branch_group(branch_group),
    .function_code(function_code),
    .reg_value(reg_value),
    .branch_address(branch_address),
    .alu_done(alu_done),
    .flags_we(flags_we),
    .negative(negative),
    .zero(zero),
    .carry(carry),
    .prog_count(prog_count),
    .flush(flush),
    .link_we(link_we),
    .link_data(link_data),
    .illegal(illegal),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic junk_fields();
    branch         = 1'($urandom);
    branch_group   = 2'($urandom);
    function_code  = 6'($urandom);
    reg_value      = $urandom;
    branch_address = $urandom;
  endtask

  task automatic wait_fetch();
    int k = 0;
    while (fetch_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("fetch_req_wait", 32'(fetch_req), 32'd1);
  endtask

  // One full instruction; expectations come from the architectural rules.
  task automatic do_instr(input logic br, input logic [1:0] grp,
                          input logic [5:0] fn, input logic [31:0] rv,
                          input logic [31:0] ba, input logic fwe,
                          input logic [2:0] nzc, input int fd,
                          input int dd, input int ad);
    logic        e_take;
    logic        e_ill;
    logic        e_link;
    logic [31:0] e_pc;
    wait_fetch();
    repeat (fd) begin
      instr_valid = 1'($urandom);
      alu_done    = 1'($urandom);
      @(negedge clk);
      check("fetch_hold", 32'(fetch_req), 32'd1);
    end
    instr_valid = 1'b0;
    alu_done    = 1'b0;
    fetch_ack   = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    check("decode_ready", 32'(instr_ready), 32'd1);
    check("decode_nofetch", 32'(fetch_req), 32'd0);
    repeat (dd) begin
      fetch_ack = 1'($urandom);
      alu_done  = 1'($urandom);
      @(negedge clk);
      check("decode_hold", 32'(instr_ready), 32'd1);
    end
    fetch_ack      = 1'b0;
    alu_done       = 1'b0;
    branch         = br;
    branch_group   = grp;
    function_code  = fn;
    reg_value      = rv;
    branch_address = ba;
    instr_valid    = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    junk_fields();
    check("exec_noready", 32'(instr_ready), 32'd0);
    if (br) begin
      alu_done = 1'b1;
      flags_we = 1'b1;
      {negative, zero, carry} = 3'($urandom);
      @(negedge clk);
    end else begin
      repeat (ad) begin
        fetch_ack   = 1'($urandom);
        instr_valid = 1'($urandom);
        flags_we    = 1'($urandom);
        {negative, zero, carry} = 3'($urandom);
        @(negedge clk);
        check("exec_wait_flags", 32'(flags), 32'(m_flags));
      end
      fetch_ack   = 1'b0;
      instr_valid = 1'b0;
      alu_done    = 1'b1;
      flags_we    = fwe;
      {negative, zero, carry} = nzc;
      @(negedge clk);
    end
    alu_done    = 1'b0;
    flags_we    = 1'b0;
    fetch_ack   = 1'b0;
    instr_valid = 1'b0;
    e_take = 1'b0;
    e_ill  = 1'b0;
    e_link = 1'b0;
    e_pc   = ba;
    if (!br) begin
      if (fwe) m_flags = nzc;
    end else if (grp == 2'd0) begin
      if (fn == 6'd0) begin
        e_take = 1'b1;
        e_pc   = rv;
      end else if (fn == 6'd1) e_take = rv[31];
      else if (fn == 6'd2) e_take = (rv == 32'd0);
      else if (fn == 6'd3) e_take = (rv != 32'd0);
      else e_ill = 1'b1;
    end else if (grp == 2'd1) begin
      if (fn == 6'd0) e_take = 1'b1;
      else if (fn == 6'd1) e_take = m_flags[0];
      else if (fn == 6'd2) e_take = !m_flags[0];
      else e_ill = 1'b1;
    end else if (grp == 2'd2 && fn == 6'd0) begin
      e_take = 1'b1;
`ifdef LINK_REG_EN
      e_link = 1'b1;
`endif
    end else begin
      e_ill = 1'b1;
    end
    if (!e_take) e_pc = m_pc + 32'd1;
    check("commit_flush", 32'(flush), 32'(e_take));
    check("commit_illegal", 32'(illegal), 32'(e_ill));
    check("commit_link_we", 32'(link_we), 32'(e_link));
    check("commit_link_data", link_data, e_link ? m_pc + 32'd1 : 32'd0);
    check("commit_flags", 32'(flags), 32'(m_flags));
    check("commit_pc_old", prog_count, m_pc);
    @(negedge clk);
    m_pc = e_pc;
    check("pc_after", prog_count, m_pc);
    check("fetch_after", 32'(fetch_req), 32'd1);
    check("flush_after", 32'(flush), 32'd0);
    check("illegal_after", 32'(illegal), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_pc"}, prog_count, RPC);
    check({tag, "_flags"}, 32'(flags), 32'd0);
    check({tag, "_fetch_req"}, 32'(fetch_req), 32'd0);
    check({tag, "_instr_ready"}, 32'(instr_ready), 32'd0);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_link_we"}, 32'(link_we), 32'd0);
    check({tag, "_link_data"}, link_data, 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_ack = 1'b0;
    instr_valid = 1'b0;
    alu_done = 1'b0;
    flags_we = 1'b0;
    {negative, zero, carry} = 3'b000;
    junk_fields();
    m_pc = RPC;
    m_flags = 3'b000;
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_cycle", 32'(fetch_req), 32'd0);
    @(negedge clk);
    check("fetch_after_idle", 32'(fetch_req), 32'd1);

    do_instr(0, 2'd0, 6'd0, 0, 0, 0, 3'b111, 0, 0, 0);
    do_instr(0, 2'd0, 6'd0, 0, 0, 1, 3'b001, 1, 1, 2);
    do_instr(1, 2'd1, 6'd1, 0, 32'h40, 0, 3'b000, 0, 0, 0);
    do_instr(1, 2'd1, 6'd2, 0, 32'h80, 0, 3'b000, 0, 0, 0);
    do_instr(1, 2'd0, 6'd1, 32'h8000_0000, 32'h200, 0, 3'b000, 0, 0, 0);
    do_instr(1, 2'd0, 6'd2, 32'h1, 32'h300, 0, 3'b000, 0, 0, 0);
    do_instr(1, 2'd0, 6'd0, 32'h1234, 32'h500, 0, 3'b000, 0, 0, 0);
    do_instr(1, 2'd0, 6'd0, 32'hFFFF_FFFF, 0, 0, 3'b000, 0, 0, 0);
    do_instr(0, 2'd0, 6'd0, 0, 0, 0, 3'b000, 0, 0, 1);
    do_instr(1, 2'd3, 6'($urandom), 0, 32'h77, 0, 3'b000, 0, 0, 0);
    do_instr(1, 2'd0, 6'd0, 32'h20, 0, 0, 3'b000, 0, 0, 0);
    do_instr(1, 2'd2, 6'd0, 0, 32'h80, 0, 3'b000, 0, 0, 0);
    do_instr(1, 2'd2, 6'd5, 0, 32'h90, 0, 3'b000, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [5:0]  fn;
      logic [31:0] rv;
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rv = 32'd0;
        1: rv = 32'h8000_0000 | $urandom;
        default: rv = $urandom;
      endcase
      do_instr(1'($urandom), 2'($urandom), fn, rv, $urandom,
               1'($urandom), 3'($urandom), $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 2));
    end

    do_instr(0, 2'd0, 6'd0, 0, 0, 1, 3'b101, 0, 0, 0);
    wait_fetch();
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    branch = 1'b0;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_pc = RPC;
    m_flags = 3'b000;
    chk_reset_outs("midexec");
    alu_done = 1'b1;
    flags_we = 1'b1;
    {negative, zero, carry} = 3'b111;
    @(negedge clk);
    alu_done = 1'b0;
    flags_we = 1'b0;
    chk_reset_outs("held");
    rst = 1'b0;
    #1;
    check("re_idle", 32'(fetch_req), 32'd0);
    @(negedge clk);
    check("re_fetch", 32'(fetch_req), 32'd1);
    check("re_pc", prog_count, RPC);
    do_instr(0, 2'd0, 6'd0, 0, 0, 0, 3'b000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: fetch_req output 1 fetch request; fetch_ack input 1 fetch complete.
REQ-005 SHALL have ports: instr_valid input 1 decoded instruction present; instr_ready output 1 sequencer accepts decode.
REQ-006 SHALL have ports: branch input 1 instruction is a branch; branch_group input 2 (00 reg-test, 01 flag, 10 link); function_code input 6.
REQ-007 SHALL have ports: reg_value input 32 source register; branch_address input 32 immediate target.
REQ-008 SHALL have ports: alu_done input 1; flags_we input 1; negative, zero, carry inputs 1 each (ALU flag results).
REQ-009 SHALL have outputs: prog_count 32; flush 1; link_we 1; link_data 32; illegal 1; flags 3 ({negative,zero,carry} registered).

Function
REQ-010 SHALL implement FSM IDLE -> FETCH -> DECODE -> EXEC -> COMMIT -> FETCH.
REQ-011 IDLE SHALL last exactly one cycle after rst deasserts, then enter FETCH.
REQ-012 FETCH SHALL hold fetch_req=1 until fetch_ack=1, then enter DECODE; fetch_req=0 in all other states.
REQ-013 DECODE SHALL drive instr_ready=1; on instr_valid=1 it SHALL capture branch, branch_group, function_code, reg_value, branch_address and enter EXEC.
REQ-014 EXEC, branch=1: SHALL resolve in one cycle and enter COMMIT.
REQ-015 EXEC, branch=0: SHALL wait for alu_done=1, then enter COMMIT; if flags_we=1 in that cycle, flags SHALL load {negative,zero,carry}.
REQ-016 Group 00 decode: 000000 br taken, target=reg_value; 000001 bltz taken if reg_value[31]; 000010 bz taken if reg_value==0; 000011 bnz taken if reg_value!=0; targets except br = branch_address.
REQ-017 Group 01 decode: 000000 b always; 000001 bcy if flags carry=1; 000010 bncy if carry=0; target=branch_address.
REQ-018 Group 10 decode: 000000 bl always taken, target=branch_address.
REQ-019 Flag branches SHALL use registered flags (from the last flag-writing instruction), never the same-cycle ALU inputs.
REQ-020 Undefined group/function_code SHALL be not taken and pulse illegal=1 for one cycle in COMMIT.
REQ-021 COMMIT SHALL load prog_count with target if taken, else prog_count+1, modulo 2^32 (32'hFFFF_FFFF+1 wraps to 0).
REQ-022 COMMIT SHALL pulse flush=1 for one cycle exactly when a branch is taken.
REQ-023 Non-branch instruction latency: prog_count updates at the rising edge ending COMMIT; minimum 4 cycles fetch_ack-to-next fetch_req with immediate instr_valid/alu_done.
REQ-024 fetch_ack, instr_valid or alu_done outside their consuming state SHALL be ignored.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, prog_count=RESET_PC, flags=3'b000, and fetch_req, instr_ready, flush, link_we, illegal=0, link_data=0, regardless of clock.
REQ-026 rst asserted mid-instruction SHALL discard captured fields; no partial commit, flag write or link write SHALL occur.

Configuration
REQ-027 Macro LINK_REG_EN defined: bl in COMMIT SHALL pulse link_we=1 with link_data=prog_count+1 (pre-update value plus one).
REQ-028 LINK_REG_EN undefined: bl SHALL behave as b; link_we and link_data SHALL be tied 0.

Verification
REQ-029 Reset RESET_PC=32'h100, release -> IDLE 1 cycle, fetch_req=1; non-branch with flags_we=0 -> prog_count=32'h101, flags unchanged.
REQ-030 ALU op alu_done with carry=1, flags_we=1; then bcy, branch_address=32'h40 -> prog_count=32'h40, flush pulse; repeat with bncy -> prog_count+1, no flush.
REQ-031 bltz with reg_value=32'h8000_0000 -> taken to branch_address; bz with reg_value=1 -> not taken; br with reg_value=32'h1234 -> prog_count=32'h1234.
REQ-032 prog_count=32'hFFFF_FFFF, non-branch -> prog_count=32'h0; group 11 any code -> illegal pulse, prog_count+1.
REQ-033 bl at prog_count=32'h20, target 32'h80: with LINK_REG_EN link_we=1, link_data=32'h21; without, link_we=0; both prog_count=32'h80.
REQ-034 Assert rst during EXEC waiting on alu_done -> prog_count=RESET_PC, flags 0, no link_we/flush pulse, restart via IDLE.
